// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the full-speed USB receive deserializer.
// Line symbol encodings are {dp, dm}; a dp1/dm1 sample is folded into SE0.
package usb_rx_pkg;

    localparam int SYNC_ZEROS_DEF = 5;
    localparam int STUFF_LEN_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP2,
        ST_WAITJ,
        ST_ERR
    } rx_state_e;

    typedef enum logic [1:0] {
        SYM_SE0 = 2'b00,
        SYM_K   = 2'b01,
        SYM_J   = 2'b10
    } line_sym_e;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } rx_beat_t;

    function automatic line_sym_e decode_sym(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return SYM_J;
            2'b01:   return SYM_K;
            default: return SYM_SE0;
        endcase
    endfunction

endpackage

// File: rtl/usb_bit_unstuff.sv
// NRZI decoder and bit-stuff remover. All outputs are combinational and
// qualified by the current bit strobe; stuffing only applies while stuff_en.
module usb_bit_unstuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_en,
    input  logic bit_strobe,
    input  logic rx_dp,
    input  logic rx_dm,
    input  logic stuff_en,
    input  logic run_set,
    output logic sym_vld,
    output logic sym_j,
    output logic sym_k,
    output logic se0,
    output logic bit_vld,
    output logic bit_val,
    output logic stuff_err
);

    localparam int RW = $clog2(STUFF_LEN + 1);

    line_sym_e     sym;
    line_sym_e     prev_sym;
    logic [RW-1:0] run;
    logic          at_limit;
    logic          non_se0;

    always_comb begin
        sym       = decode_sym(rx_dp, rx_dm);
        sym_vld   = rx_en && bit_strobe;
        non_se0   = sym_vld && (sym != SYM_SE0);
        se0       = sym_vld && (sym == SYM_SE0);
        sym_j     = sym_vld && (sym == SYM_J);
        sym_k     = sym_vld && (sym == SYM_K);
        bit_val   = (sym == prev_sym);
        at_limit  = stuff_en && (run == RW'(STUFF_LEN));
        // the bit after a full run of ones must be a stuffed 0: drop it, or flag a 1
        bit_vld   = non_se0 && !at_limit;
        stuff_err = non_se0 && at_limit && bit_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sym <= SYM_J;
            run      <= '0;
        end else if (!rx_en) begin
            prev_sym <= SYM_J;
            run      <= '0;
        end else begin
            if (non_se0)
                prev_sym <= sym;
            if (run_set)
                run <= RW'(1);
            else if (non_se0 && stuff_en)
                run <= (at_limit || !bit_val) ? '0 : run + RW'(1);
        end
    end

endmodule

// File: rtl/usb_rx_deserial.sv
// USB full-speed receive front end: SYNC detect, byte assembly, EOP detect.
// One byte is held back so the last byte of a packet can carry rx_eop.
module usb_rx_deserial
    import usb_rx_pkg::*;
#(
    parameter int SYNC_ZEROS = SYNC_ZEROS_DEF,
    parameter int STUFF_LEN  = STUFF_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       bit_strobe,
    input  logic       rx_dp,
    input  logic       rx_dm,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_data_on,
    output logic       rx_err
);

    localparam int SCW = $clog2(SYNC_ZEROS + 1);

    rx_state_e      state, state_nxt;
    logic [SCW-1:0] sync_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [7:0]     held;
    logic           held_vld;
    logic           held_first;

    logic           sym_vld, sym_j, sym_k, se0;
    logic           bit_vld, bit_val, stuff_err;
    logic           stuff_en, sync_ok, accept, byte_done, line_idle, err_set;
    logic [7:0]     byte_nxt;
    rx_beat_t       beat;

    usb_bit_unstuff #(.STUFF_LEN(STUFF_LEN)) u_unstuff (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .bit_strobe(bit_strobe),
        .rx_dp     (rx_dp),
        .rx_dm     (rx_dm),
        .stuff_en  (stuff_en),
        .run_set   (accept),
        .sym_vld   (sym_vld),
        .sym_j     (sym_j),
        .sym_k     (sym_k),
        .se0       (se0),
        .bit_vld   (bit_vld),
        .bit_val   (bit_val),
        .stuff_err (stuff_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else if (!rx_en)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sym_k) state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (se0)
                    state_nxt = ST_IDLE;
                else if (bit_vld && bit_val)
                    state_nxt = sync_ok ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                if (stuff_err)
                    state_nxt = ST_ERR;
                else if (se0)
                    state_nxt = (bit_cnt == 3'd0) ? ST_EOP2 : ST_ERR;
            end
            ST_EOP2:  if (sym_vld) state_nxt = se0 ? ST_WAITJ : ST_ERR;
            ST_WAITJ,
            ST_ERR:   if (sym_j) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stuff_en  = (state == ST_DATA);
        sync_ok   = (sync_cnt >= SCW'(SYNC_ZEROS));
        accept    = (state == ST_SYNC) && bit_vld && bit_val && sync_ok;
        byte_nxt  = {bit_val, shreg[7:1]};
        byte_done = (state == ST_DATA) && bit_vld && (bit_cnt == 3'd7);
        line_idle = ((state == ST_WAITJ) || (state == ST_ERR)) && sym_j;
        err_set   = stuff_err
                  || ((state == ST_DATA) && se0 && (bit_cnt != 3'd0))
                  || ((state == ST_EOP2) && sym_vld && !se0);
        beat       = '0;
        beat.data  = held;
        beat.sop   = held_first;
        // a completed byte releases the previous one; the second EOP SE0 releases the last
        if (byte_done && held_vld) begin
            beat.valid = 1'b1;
        end else if ((state == ST_EOP2) && se0 && held_vld) begin
            beat.valid = 1'b1;
            beat.eop   = 1'b1;
        end
        if (!beat.valid)
            beat.sop = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            rx_data_on <= 1'b0;
            rx_err     <= 1'b0;
        end else if (!rx_en) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sop     <= 1'b0;
            rx_eop     <= 1'b0;
            rx_data_on <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_valid <= beat.valid;
            rx_sop   <= beat.sop;
            rx_eop   <= beat.eop;
            rx_err   <= err_set;
            if (beat.valid)
                rx_data <= beat.data;
            if (accept)
                rx_data_on <= 1'b1;
            else if (line_idle)
                rx_data_on <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            held       <= '0;
            held_vld   <= 1'b0;
            held_first <= 1'b0;
        end else if (!rx_en) begin
            sync_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            held       <= '0;
            held_vld   <= 1'b0;
            held_first <= 1'b0;
        end else begin
            // the K leaving idle is itself the first decoded 0 of SYNC
            if ((state == ST_IDLE) && sym_k)
                sync_cnt <= SCW'(1);
            else if ((state == ST_SYNC) && bit_vld && !bit_val && !sync_ok)
                sync_cnt <= sync_cnt + SCW'(1);

            if (accept) begin
                bit_cnt    <= '0;
                held_vld   <= 1'b0;
                held_first <= 1'b0;
            end else if ((state == ST_DATA) && bit_vld) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= byte_nxt;
                if (byte_done) begin
                    held       <= byte_nxt;
                    held_vld   <= 1'b1;
                    held_first <= !held_vld;
                end
            end else if (beat.eop || line_idle) begin
                held_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_deserial.sv
// Bench for usb_rx_deserial: packets are NRZI/stuff-encoded from byte lists and
// each line symbol carries the output event it must cause one cycle later.
module tb_usb_rx_deserial;

    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    logic       clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, bit_strobe = 1'b0;
    logic       rx_dp = 1'b1, rx_dm = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sop, rx_eop, rx_data_on, rx_err;

    usb_rx_deserial dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .bit_strobe(bit_strobe),
        .rx_dp(rx_dp), .rx_dm(rx_dm), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_data_on(rx_data_on), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sym;
        logic       vld, sop, eop, err, on_set, on_clr;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] pkt[$];
    logic [9:0] seen[$];
    logic [1:0] lvl = J;
    int         run = 0;
    int         n_cmp = 0, n_bad = 0, n_err_seen = 0;
    logic       exp_valid = 1'b0, exp_sop = 1'b0, exp_eop = 1'b0, exp_err = 1'b0, exp_on = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rx_valid",   32'(rx_valid),   32'(exp_valid));
        chk("rx_sop",     32'(rx_sop),     32'(exp_sop));
        chk("rx_eop",     32'(rx_eop),     32'(exp_eop));
        chk("rx_err",     32'(rx_err),     32'(exp_err));
        chk("rx_data_on", 32'(rx_data_on), 32'(exp_on));
        chk("rx_data",    32'(rx_data),    32'(exp_data));
        if (rx_valid) seen.push_back({rx_sop, rx_eop, rx_data});
        if (rx_err) n_err_seen++;
    end

    // ---------------- packet model ----------------
    task automatic put(input logic [1:0] s, input ev_t e);
        ev_t x;
        x = e;
        x.sym = s;
        evq.push_back(x);
    endtask

    task automatic enc(input logic b, input ev_t e);
        if (!b) lvl = (lvl == J) ? K : J;
        put(lvl, e);
    endtask

    task automatic enc_data(input logic b, input ev_t e);
        enc(b, e);
        if (b) begin
            run++;
            if (run == 6) begin
                enc(1'b0, '0);
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic b_sync(input int nz);
        ev_t e;
        for (int i = 0; i < nz; i++) enc(1'b0, '0);
        e = '0;
        e.on_set = 1'b1;
        enc(1'b1, e);
        run = 1;
    endtask

    task automatic b_bytes();
        ev_t  e;
        logic [7:0] cur;
        for (int i = 0; i < pkt.size(); i++) begin
            cur = pkt[i];
            for (int k = 0; k < 8; k++) begin
                e = '0;
                if (k == 7 && i > 0) begin
                    e.vld  = 1'b1;
                    e.data = pkt[i-1];
                    e.sop  = (i == 1);
                end
                enc_data(cur[k], e);
            end
        end
    endtask

    task automatic b_eop();
        ev_t e;
        put(SE0, '0);
        e = '0;
        if (pkt.size() > 0) begin
            e.vld  = 1'b1;
            e.data = pkt[pkt.size()-1];
            e.sop  = (pkt.size() == 1);
            e.eop  = 1'b1;
        end
        put(SE0, e);
        e = '0;
        e.on_clr = 1'b1;
        put(J, e);
        lvl = J;
    endtask

    task automatic b_idle(input int n);
        for (int i = 0; i < n; i++) put(J, '0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input ev_t e);
        @(posedge clk); #1;
        rx_dp = e.sym[1];
        rx_dm = e.sym[0];
        bit_strobe = 1'b1;
        @(posedge clk); #1;
        bit_strobe = 1'b0;
        exp_valid = e.vld; exp_sop = e.sop; exp_eop = e.eop; exp_err = e.err;
        if (e.vld) exp_data = e.data;
        if (e.on_set) exp_on = 1'b1;
        if (e.on_clr) exp_on = 1'b0;
        @(posedge clk); #1;
        exp_valid = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_err = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic play();
        while (evq.size() > 0) drive(evq.pop_front());
    endtask

    task automatic exp_clear();
        exp_valid = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0; exp_err = 1'b0;
        exp_on = 1'b0; exp_data = 8'h00;
    endtask

    task automatic clean_pkt(input string nm, input logic [7:0] b);
        seen.delete();
        lvl = J;
        b_idle(2);
        b_sync(7);
        pkt.delete();
        pkt.push_back(b);
        b_bytes();
        b_eop();
        play();
        chk({nm, "_count"}, 32'(seen.size()), 32'd1);
        if (seen.size() > 0) chk({nm, "_beat"}, 32'(seen[0]), 32'({2'b11, b}));
    endtask

    task automatic mid_packet_two_bytes(input logic [7:0] b0, input logic [7:0] b1);
        lvl = J;
        b_idle(1);
        b_sync(7);
        pkt.delete();
        pkt.push_back(b0);
        pkt.push_back(b1);
        b_bytes();
        play();
        chk("mid_on_before", 32'(rx_data_on), 32'd1);
        chk("mid_data_before", 32'(rx_data), 32'(b0));
    endtask

    initial begin : main
        logic [15:0] sync_ref;
        ev_t         e;
        int          errs0, n;
        logic [7:0]  b0, b1;

        // pin the encoder itself against hand-derived symbol streams
        sync_ref = {K, J, K, J, K, J, K, K};
        lvl = J;
        b_sync(7);
        for (int i = 0; i < 8; i++)
            chk("model_sync_sym", 32'(evq[i].sym), 32'(sync_ref[15-2*i -: 2]));
        pkt.delete();
        pkt.push_back(8'hFF);
        b_bytes();
        chk("model_ff_len", 32'(evq.size()), 32'd17);
        chk("model_ff_k", 32'(evq[12].sym), 32'(K));
        chk("model_ff_stuff", 32'(evq[13].sym), 32'(J));
        evq.delete();
        lvl = J;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({rx_data, rx_valid, rx_sop, rx_eop, rx_data_on, rx_err}), 32'd0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (2) @(posedge clk);

        // two-byte packet
        seen.delete();
        b_idle(2);
        b_sync(7);
        pkt.delete(); pkt.push_back(8'hA5); pkt.push_back(8'h3C);
        b_bytes();
        b_eop();
        play();
        chk("t1_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("t1_beat0", 32'(seen[0]), 32'h2A5);
            chk("t1_beat1", 32'(seen[1]), 32'h13C);
        end
        chk("t1_on_end", 32'(rx_data_on), 32'd0);

        // 0xFF with a stuffed zero
        seen.delete();
        errs0 = n_err_seen;
        b_sync(7);
        pkt.delete(); pkt.push_back(8'hFF);
        b_bytes();
        b_eop();
        play();
        chk("t2_count", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) chk("t2_beat", 32'(seen[0]), 32'h3FF);
        chk("t2_no_err", 32'(n_err_seen - errs0), 32'd0);

        // seven consecutive ones after a full byte
        seen.delete();
        errs0 = n_err_seen;
        b_sync(7);
        pkt.delete(); pkt.push_back(8'($urandom_range(0, 255)));
        b_bytes();
        enc(1'b0, '0);
        for (int i = 0; i < 6; i++) enc(1'b1, '0);
        e = '0; e.err = 1'b1;
        enc(1'b1, e);
        put(SE0, '0);
        e = '0; e.on_clr = 1'b1;
        put(J, e);
        lvl = J;
        play();
        chk("t3_err_once", 32'(n_err_seen - errs0), 32'd1);
        chk("t3_no_beat", 32'(seen.size()), 32'd0);

        // SE0 three bits into byte 2, then a clean packet
        seen.delete();
        errs0 = n_err_seen;
        b_sync(7);
        pkt.delete(); pkt.push_back(8'($urandom_range(0, 255)));
        b_bytes();
        for (int i = 0; i < 3; i++) enc_data(1'($urandom_range(0, 1)), '0);
        e = '0; e.err = 1'b1;
        put(SE0, e);
        e = '0; e.on_clr = 1'b1;
        put(J, e);
        lvl = J;
        play();
        chk("t4_err_once", 32'(n_err_seen - errs0), 32'd1);
        chk("t4_no_beat", 32'(seen.size()), 32'd0);
        clean_pkt("t4_after", 8'h12);

        // short SYNCs (3 and 4 zeros), then minimum SYNC straight into EOP
        seen.delete();
        errs0 = n_err_seen;
        for (int i = 0; i < 3; i++) enc(1'b0, '0);
        enc(1'b1, '0);
        lvl = J;
        b_idle(2);
        for (int i = 0; i < 4; i++) enc(1'b0, '0);
        enc(1'b1, '0);
        b_idle(2);
        b_sync(5);
        pkt.delete();
        b_eop();
        play();
        chk("t5_no_beat", 32'(seen.size()), 32'd0);
        chk("t5_no_err", 32'(n_err_seen - errs0), 32'd0);

        // reset mid-packet
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        mid_packet_two_bytes(b0, b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rx_dp = 1'b1; rx_dm = 1'b0;
        exp_clear();
        #1;
        chk("rst_mid_outputs", 32'({rx_data, rx_valid, rx_sop, rx_eop, rx_data_on, rx_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clean_pkt("t6_rst_after", 8'h69);

        // rx_en drop mid-packet
        mid_packet_two_bytes(b1, b0);
        @(posedge clk); #1;
        rx_en = 1'b0;
        rx_dp = 1'b1; rx_dm = 1'b0;
        @(posedge clk); #1;
        exp_clear();
        chk("en_mid_outputs", 32'({rx_data, rx_valid, rx_sop, rx_eop, rx_data_on, rx_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rx_en = 1'b1;
        clean_pkt("t6_en_after", 8'h69);

        // random packets
        for (int p = 0; p < 12; p++) begin
            seen.delete();
            errs0 = n_err_seen;
            lvl = J;
            b_idle($urandom_range(0, 3));
            b_sync($urandom_range(5, 7));
            pkt.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            b_bytes();
            b_eop();
            play();
            chk("rnd_count", 32'(seen.size()), 32'(n));
            for (int i = 0; i < n && i < seen.size(); i++)
                chk("rnd_beat", 32'(seen[i]), 32'({(i == 0), (i == n - 1), pkt[i]}));
            chk("rnd_no_err", 32'(n_err_seen - errs0), 32'd0);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
